// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: register offsets, window base and TX_STAT layout shared by the
// io_ctrl block. The optional cycle counter is enabled with IO_CTRL_CYCLE_EN.
package io_ctrl_pkg;

    // Upper address byte that selects the I/O window 0xFF00-0xFFFF.
    localparam logic [7:0] IO_BASE_HI = 8'hFF;

    // Register offsets within the window (io_addr[7:0]).
    localparam logic [7:0] IO_LED = 8'h00;
    localparam logic [7:0] IO_SW  = 8'h04;
    localparam logic [7:0] IO_BTN = 8'h08;
    localparam logic [7:0] IO_TXD = 8'h0C;
    localparam logic [7:0] IO_TXS = 8'h10;
    localparam logic [7:0] IO_CYC = 8'h14;

    // TX_STAT bit positions.
    localparam int TXS_FULL_BIT  = 0;
    localparam int TXS_EMPTY_BIT = 1;
    localparam int TXS_OVF_BIT   = 2;
    localparam int TXS_CNT_LSB   = 4;
    localparam int TXS_CNT_W     = 9;

    typedef struct packed {
        logic                 full;
        logic                 empty;
        logic                 ovf;
        logic [TXS_CNT_W-1:0] count;
    } tx_stat_t;

    // Places the status fields at their register bit positions.
    function automatic logic [31:0] pack_tx_stat(input tx_stat_t s);
        logic [31:0] w;
        w = '0;
        w[TXS_FULL_BIT]                   = s.full;
        w[TXS_EMPTY_BIT]                  = s.empty;
        w[TXS_OVF_BIT]                    = s.ovf;
        w[TXS_CNT_LSB +: TXS_CNT_W]       = s.count;
        return w;
    endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// io_ctrl_if: the data-memory unit's I/O bus. The CPU side is the master,
// the io_ctrl register block is the slave that returns combinational read data.
interface io_ctrl_if;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (output io_addr, output io_dout, output io_we, output io_rd,
                    input  io_din);
    modport slave  (input  io_addr, input  io_dout, input  io_we, input  io_rd,
                    output io_din);
endinterface

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: byte circular buffer for the TX port. Pointers wrap naturally;
// a push into a full FIFO only succeeds when a pop happens in the same cycle.
module io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_count;
    logic        w_do_push, w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte storage written on an accepted push.
    // NOTE: the storage array has no reset; stale entries are never visible because head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

    assign head = empty ? 8'h00 : r_mem[r_rptr];

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O controller for the 0xFF00-0xFFFF window.
// LED register, synchronized switches, sticky button-edge flag, TX byte FIFO,
// and an optional free-running cycle counter enabled by IO_CTRL_CYCLE_EN.
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    io_ctrl_if.slave    bus,
    output logic [15:0] led,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_sel, w_wr, w_rd;
    logic [7:0]    w_off;
    logic          w_push, w_pop, w_full, w_empty, w_ovf_set, w_btn_rise;
    logic [CW-1:0] w_count;
    logic [31:0]   w_rdata;
    tx_stat_t      w_stat;

    logic [15:0]   r_led, r_sw_s1, r_sw_s2;
    logic          r_btn_s1, r_btn_s2, r_btn_s3;
    logic          r_btn_flag, r_ovf;

    assign w_sel = (bus.io_addr[15:8] == IO_BASE_HI);
    assign w_wr  = bus.io_we && w_sel;
    assign w_rd  = bus.io_rd && w_sel;
    assign w_off = bus.io_addr[7:0];

    assign w_push     = w_wr && (w_off == IO_TXD);
    assign w_pop      = tx_valid && tx_ready;
    assign w_ovf_set  = w_push && w_full && !w_pop;
    assign w_btn_rise = r_btn_s2 && !r_btn_s3;

    io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .din   (bus.io_dout[7:0]),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (tx_data)
    );

    assign tx_valid = !w_empty;
    assign led      = r_led;

    // LED register loads on a decoded store.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          r_led <= '0;
        else if (w_wr && w_off == IO_LED)   r_led <= bus.io_dout[15:0];
    end

    // Two-flop switch synchronizer and three-flop button chain (third flop for edge detect).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_s3 <= 1'b0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_s3 <= r_btn_s2;
        end
    end

    // Sticky flags: a new event in the same cycle as the clearing read keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_btn_flag <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_btn_rise)                    r_btn_flag <= 1'b1;
            else if (w_rd && w_off == IO_BTN)  r_btn_flag <= 1'b0;
            if (w_ovf_set)                     r_ovf <= 1'b1;
            else if (w_rd && w_off == IO_TXS)  r_ovf <= 1'b0;
        end
    end

`ifdef IO_CTRL_CYCLE_EN
    logic [31:0] r_cycle;

    // Free-running cycle counter, loadable by a store to CYCLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          r_cycle <= '0;
        else if (w_wr && w_off == IO_CYC)   r_cycle <= bus.io_dout;
        else                                r_cycle <= r_cycle + 32'd1;
    end
`else
    // Upper store-data bits only feed the counter, which is absent in this build.
    logic w_unused;
    assign w_unused = &{1'b0, bus.io_dout[31:16]};
`endif

    assign w_stat.full  = w_full;
    assign w_stat.empty = w_empty;
    assign w_stat.ovf   = r_ovf;
    assign w_stat.count = TXS_CNT_W'(w_count);

    // Combinational read mux; unmapped offsets and addresses outside the window read 0.
    // NOTE: the default is assigned first so no path through the case leaves w_rdata unassigned (no latch).
    always_comb begin
        w_rdata = '0;
        if (w_sel) begin
            case (w_off)
                IO_LED: w_rdata = {16'h0000, r_led};
                IO_SW:  w_rdata = {16'h0000, r_sw_s2};
                IO_BTN: w_rdata = {31'd0, r_btn_flag};
                IO_TXS: w_rdata = pack_tx_stat(w_stat);
`ifdef IO_CTRL_CYCLE_EN
                IO_CYC: w_rdata = r_cycle;
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.io_din = w_rdata;

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: self-checking bench for io_ctrl with a queue-based reference model.
module tb_io_ctrl;
    localparam int DEPTH = 8;
`ifdef IO_CTRL_CYCLE_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] led;
    logic [15:0] sw;
    logic        btn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    io_ctrl_if bus ();

    io_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .led      (led),
        .sw       (sw),
        .btn      (btn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic [15:0] m_led;
    logic [31:0] m_cyc;

    // Sampled DUT outputs and model expectations for the last cycle.
    logic [31:0] s_din, e_din;
    logic        s_valid, e_valid;
    logic [7:0]  s_data, e_data;
    logic [15:0] s_led, e_led;

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [31:0] v;
        int n;
        n = m_q.size();
        case (off)
            8'h00:   v = {16'h0000, m_led};
            8'h04:   v = {16'h0000, sw};
            8'h10:   v = (32'(n) << 4) | (m_ovf ? 32'd4 : 32'd0) |
                         ((n == 0) ? 32'd2 : 32'd0) | ((n == DEPTH) ? 32'd1 : 32'd0);
            8'h14:   v = CYC_EN ? m_cyc : 32'h0;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Samples outputs before the edge, advances the model, then steps past the edge.
    task automatic tick();
        logic       sel, wr, rd, pop, full_b, ovf_set;
        logic [7:0] off;
        @(negedge clk);
        s_din   = bus.io_din;
        s_valid = tx_valid;
        s_data  = tx_data;
        s_led   = led;
        off     = bus.io_addr[7:0];
        e_din   = model_read(off);
        e_valid = (m_q.size() != 0);
        e_data  = e_valid ? m_q[0] : 8'h00;
        e_led   = m_led;
        sel     = (bus.io_addr[15:8] == 8'hFF);
        wr      = bus.io_we && sel;
        rd      = bus.io_rd && sel;
        pop     = e_valid && tx_ready;
        full_b  = (m_q.size() == DEPTH);
        ovf_set = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 8'h0C) begin
            if (!full_b || pop) m_q.push_back(bus.io_dout[7:0]);
            else                ovf_set = 1'b1;
        end
        if (ovf_set)                   m_ovf = 1'b1;
        else if (rd && off == 8'h10)   m_ovf = 1'b0;
        if (wr && off == 8'h00)        m_led = bus.io_dout[15:0];
        if (CYC_EN && wr && off == 8'h14) m_cyc = bus.io_dout;
        else                              m_cyc = m_cyc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [31:0] d,
                         input logic we, input logic rd);
        bus.io_addr = a;
        bus.io_dout = d;
        bus.io_we   = we;
        bus.io_rd   = rd;
        tick();
        bus.io_we   = 1'b0;
        bus.io_rd   = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_led = 16'h0000;
        m_cyc = 32'h0;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        bus.io_addr = 16'h0000;
        bus.io_dout = 32'h0;
        bus.io_we   = 1'b0;
        bus.io_rd   = 1'b0;
        sw          = 16'h0000;
        btn         = 1'b0;
        tx_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(16'hFF10, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h00000002) begin fails++; $display("FAIL reset_txs: got %h want %h", s_din, 32'h2); end
        tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        tests++; if (s_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", s_data); end
        tests++; if (s_led !== 16'h0000) begin fails++; $display("FAIL reset_led: got %h want 0000", s_led); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL reset_btn: got %h want 0", s_din); end
    endtask

    task automatic test_led();
        logic [31:0] v;
        drive(16'hFF00, 32'h1234ABCD, 1'b1, 1'b0);
        drive(16'hFF00, 32'h0, 1'b0, 1'b0);
        tests++; if (s_led !== 16'hABCD) begin fails++; $display("FAIL led_write: got %h want abcd", s_led); end
        tests++; if (s_din !== 32'h0000ABCD) begin fails++; $display("FAIL led_read: got %h want 0000abcd", s_din); end
        drive(16'h0000, 32'h55555555, 1'b1, 1'b0);
        drive(16'hFF00, 32'h0, 1'b0, 1'b0);
        tests++; if (s_led !== 16'hABCD) begin fails++; $display("FAIL led_outside_window: got %h want abcd", s_led); end
        drive(16'hFF40, 32'h55555555, 1'b1, 1'b0);
        drive(16'hFF40, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h want 0", s_din); end
        tests++; if (s_led !== 16'hABCD) begin fails++; $display("FAIL unmapped_write: got %h want abcd", s_led); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            drive(16'hFF00, v, 1'b1, 1'b0);
            drive(16'hFF00, 32'h0, 1'b0, 1'b0);
            tests++; if (s_led !== v[15:0]) begin fails++; $display("FAIL led_rand: got %h want %h", s_led, v[15:0]); end
            tests++; if (s_din !== e_din) begin fails++; $display("FAIL led_rand_read: got %h want %h", s_din, e_din); end
        end
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) drive(16'hFF0C, 32'(i), 1'b1, 1'b0);
        drive(16'hFF10, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h00000085) begin fails++; $display("FAIL ovf_stat: got %h want 00000085", s_din); end
        tests++; if (s_valid !== 1'b1 || s_data !== 8'h01) begin fails++; $display("FAIL ovf_head: got %b/%h want 1/01", s_valid, s_data); end
        drive(16'hFF10, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h00000081) begin fails++; $display("FAIL ovf_cleared: got %h want 00000081", s_din); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [8];
        int k;
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        tx_ready = 1'b1;
        drive(16'hFF0C, 32'h55, 1'b1, 1'b0);
        tx_ready = 1'b0;
        drive(16'hFF10, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h00000081) begin fails++; $display("FAIL full_pushpop_stat: got %h want 00000081", s_din); end
        tests++; if (s_data !== 8'h02) begin fails++; $display("FAIL full_pushpop_head: got %h want 02", s_data); end
        k = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && k < 8; c++) begin
            drive(16'hFF10, 32'h0, 1'b0, 1'b0);
            if (s_valid) begin
                tests++; if (s_data !== exp_seq[k]) begin fails++; $display("FAIL drain_byte%0d: got %h want %h", k, s_data, exp_seq[k]); end
                k++;
            end
        end
        tx_ready = 1'b0;
        tests++; if (k != 8) begin fails++; $display("FAIL drain_count: got %0d want 8", k); end
        drive(16'hFF10, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h00000002) begin fails++; $display("FAIL drained_stat: got %h want 00000002", s_din); end
    endtask

    task automatic test_sw();
        logic [15:0] old_v, new_v;
        for (int r = 0; r < 4; r++) begin
            old_v = sw;
            new_v = old_v ^ (16'($urandom) | 16'h0001);
            sw = new_v;
            drive(16'hFF04, 32'h0, 1'b0, 1'b0);
            tests++; if (s_din !== {16'h0, old_v}) begin fails++; $display("FAIL sw_lat0: got %h want %h", s_din, {16'h0, old_v}); end
            drive(16'hFF04, 32'h0, 1'b0, 1'b0);
            tests++; if (s_din !== {16'h0, old_v}) begin fails++; $display("FAIL sw_lat1: got %h want %h", s_din, {16'h0, old_v}); end
            drive(16'hFF04, 32'h0, 1'b0, 1'b0);
            tests++; if (s_din !== {16'h0, new_v}) begin fails++; $display("FAIL sw_lat2: got %h want %h", s_din, {16'h0, new_v}); end
        end
    endtask

    task automatic test_btn();
        btn = 1'b1;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL btn_early: got %h want 0", s_din); end
        btn = 1'b0;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL btn_cycle3: got %h want 0", s_din); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_set: got %h want 1", s_din); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_sticky: got %h want 1", s_din); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_clear_read: got %h want 1", s_din); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL btn_cleared: got %h want 0", s_din); end

        // Set the flag again, let the chain settle low, then align a new edge with the clearing read.
        btn = 1'b1;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        btn = 1'b0;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_reset2: got %h want 1", s_din); end
        repeat (3) drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        btn = 1'b1;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        drive(16'hFF08, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_coincident_read: got %h want 1", s_din); end
        btn = 1'b0;
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h1) begin fails++; $display("FAIL btn_edge_wins: got %h want 1", s_din); end
        drive(16'hFF08, 32'h0, 1'b0, 1'b1);
        drive(16'hFF08, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL btn_final_clear: got %h want 0", s_din); end
    endtask

    task automatic test_cycle();
`ifdef IO_CTRL_CYCLE_EN
        drive(16'hFF14, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== e_din) begin fails++; $display("FAIL cyc_free: got %h want %h", s_din, e_din); end
        drive(16'hFF14, 32'hFFFFFFFE, 1'b1, 1'b0);
        drive(16'hFF00, 32'h0, 1'b0, 1'b0);
        drive(16'hFF14, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'hFFFFFFFF) begin fails++; $display("FAIL cyc_max: got %h want ffffffff", s_din); end
        drive(16'hFF14, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h00000000) begin fails++; $display("FAIL cyc_wrap: got %h want 00000000", s_din); end
`else
        drive(16'hFF14, 32'hFFFFFFFE, 1'b1, 1'b0);
        drive(16'hFF14, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL cyc_absent0: got %h want 0", s_din); end
        drive(16'hFF14, 32'h0, 1'b0, 1'b1);
        tests++; if (s_din !== 32'h0) begin fails++; $display("FAIL cyc_absent1: got %h want 0", s_din); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [31:0] d;
        logic        we, rd;
        int          op;
        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 7);
            d  = $urandom;
            we = 1'b0;
            rd = 1'b0;
            case (op)
                0, 1, 2: begin a = 16'hFF0C; we = 1'b1; end
                3:       begin a = 16'hFF10; rd = 1'b1; end
                4:       begin a = 16'hFF00; we = 1'b1; end
                5:       begin a = 16'hFF00; end
                6:       begin a = {8'($urandom_range(0, 254)), 8'h0C}; we = 1'b1; end
                default: begin a = {8'($urandom_range(0, 254)), 8'h10}; rd = 1'b1; end
            endcase
            drive(a, d, we, rd);
            tests++; if (s_valid !== e_valid) begin fails++; $display("FAIL rand_valid[%0d]: got %b want %b", i, s_valid, e_valid); end
            if (e_valid) begin
                tests++; if (s_data !== e_data) begin fails++; $display("FAIL rand_data[%0d]: got %h want %h", i, s_data, e_data); end
            end
            tests++; if (s_led !== e_led) begin fails++; $display("FAIL rand_led[%0d]: got %h want %h", i, s_led, e_led); end
            if (a[15:8] == 8'hFF) begin
                tests++; if (s_din !== e_din) begin fails++; $display("FAIL rand_din[%0d] addr %h: got %h want %h", i, a, s_din, e_din); end
            end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        drive(16'hFF00, 32'h0000BEEF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(16'hFF0C, 32'(8'hA0 + i), 1'b1, 1'b0);
        bus.io_addr = 16'hFF10;
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want 0", tx_valid); end
        tests++; if (led !== 16'h0000) begin fails++; $display("FAIL midreset_led: got %h want 0000", led); end
        tests++; if (bus.io_din !== 32'h00000002) begin fails++; $display("FAIL midreset_stat: got %h want 00000002", bus.io_din); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        drive(16'hFF10, 32'h0, 1'b0, 1'b0);
        tests++; if (s_din !== 32'h00000002) begin fails++; $display("FAIL postreset_stat: got %h want 00000002", s_din); end
        tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL postreset_valid: got %b want 0", s_valid); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_led();
        test_fifo_overflow();
        test_full_push_pop();
        test_sw();
        test_btn();
        test_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
